// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 burst memory slave (FIXED/INCR/WRAP, byte strobes, SLVERR)
// Define AXI4_BURST_MEM_WRAP_EN to support WRAP bursts; otherwise AxBURST=2'b10 is an error burst.
module axi4_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [2:0]                      ARSIZE,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);
  localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IW    = C_S_AXI_ADDR_WIDTH - LSB;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e                    w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] aw_id_q, aw_id_d;
  logic [IW-1:0]               w_idx_q, w_idx_d, w_idx_next;
  logic [7:0]                  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]                  w_burst_q, w_burst_d;
  logic                        w_err_q, w_err_d, w_last, mem_we;

  r_state_e                    r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [IW-1:0]               r_idx_q, r_idx_d, r_idx_next, rd_idx;
  logic [7:0]                  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]                  r_burst_q, r_burst_d;
  logic                        r_err_q, r_err_d, r_last;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;

  logic aw_wrap_bad, ar_wrap_bad, unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

`ifdef AXI4_BURST_MEM_WRAP_EN
  logic [IW-1:0] w_mask, r_mask;
  assign w_mask      = IW'(w_len_q);
  assign r_mask      = IW'(r_len_q);
  assign aw_wrap_bad = (AWBURST == 2'b10) && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign ar_wrap_bad = (ARBURST == 2'b10) && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
  assign aw_wrap_bad = (AWBURST == 2'b10);
  assign ar_wrap_bad = (ARBURST == 2'b10);
`endif

  // Word-index advance; FIXED and error bursts stay put.
  always_comb begin
    w_idx_next = w_idx_q;
    r_idx_next = r_idx_q;
    case (w_burst_q)
      2'b01:   w_idx_next = w_idx_q + 1'b1;
`ifdef AXI4_BURST_MEM_WRAP_EN
      2'b10:   w_idx_next = (w_idx_q & ~w_mask) | ((w_idx_q + 1'b1) & w_mask);
`endif
      default: w_idx_next = w_idx_q;
    endcase
    case (r_burst_q)
      2'b01:   r_idx_next = r_idx_q + 1'b1;
`ifdef AXI4_BURST_MEM_WRAP_EN
      2'b10:   r_idx_next = (r_idx_q & ~r_mask) | ((r_idx_q + 1'b1) & r_mask);
`endif
      default: r_idx_next = r_idx_q;
    endcase
  end

  assign w_last = (w_cnt_q == w_len_q);
  assign r_last = (r_cnt_q == r_len_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_RST;
      r_state_q <= R_RST;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_RST:   w_state_d = W_IDLE;
      W_IDLE:  if (AWVALID) w_state_d = W_DATA;
      W_DATA:  if (WVALID && w_last) w_state_d = W_RESP;
      W_RESP:  if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    r_state_d = r_state_q;
    case (r_state_q)
      R_RST:   r_state_d = R_IDLE;
      R_IDLE:  if (ARVALID) r_state_d = R_DATA;
      R_DATA:  if (RREADY && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (w_state_q == W_IDLE);
    WREADY  = (w_state_q == W_DATA);
    BVALID  = (w_state_q == W_RESP);
    BID     = BVALID ? aw_id_q : '0;
    BRESP   = (BVALID && w_err_q) ? 2'b10 : 2'b00;
    ARREADY = (r_state_q == R_IDLE);
    RVALID  = (r_state_q == R_DATA);
    RID     = RVALID ? ar_id_q : '0;
    RRESP   = (RVALID && r_err_q) ? 2'b10 : 2'b00;
    RLAST   = RVALID && r_last;
    RDATA   = rdata_q;
  end

  always_comb begin
    aw_id_d   = aw_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    if (w_state_q == W_IDLE && AWVALID) begin
      aw_id_d   = AWID;
      w_idx_d   = AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
      w_len_d   = AWLEN;
      w_cnt_d   = 8'd0;
      w_burst_d = AWBURST;
      w_err_d   = (AWSIZE != 3'(LSB)) || (AWBURST == 2'b11) || aw_wrap_bad;
    end else if (w_state_q == W_DATA && WVALID) begin
      mem_we  = !w_err_q;
      w_idx_d = w_idx_next;
      w_cnt_d = w_cnt_q + 8'd1;
      if (WLAST != w_last) w_err_d = 1'b1;
    end
  end

  // The read word is fetched one edge ahead into rdata_q so stalls hold it stable
  // and a same-cycle write to that word is seen as the old value.
  assign rd_idx  = (r_state_q == R_IDLE) ? ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB] : r_idx_next;
  assign rd_word = mem[rd_idx];

  always_comb begin
    ar_id_d   = ar_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rdata_d   = rdata_q;
    if (r_state_q == R_IDLE && ARVALID) begin
      ar_id_d   = ARID;
      r_idx_d   = rd_idx;
      r_len_d   = ARLEN;
      r_cnt_d   = 8'd0;
      r_burst_d = ARBURST;
      r_err_d   = (ARSIZE != 3'(LSB)) || (ARBURST == 2'b11) || ar_wrap_bad;
      rdata_d   = r_err_d ? '0 : rd_word;
    end else if (r_state_q == R_DATA && RREADY) begin
      r_idx_d = r_idx_next;
      r_cnt_d = r_cnt_q + 8'd1;
      rdata_d = (r_last || r_err_q) ? '0 : rd_word;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_id_q   <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      ar_id_q   <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_id_q   <= aw_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      ar_id_q   <= ar_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (WSTRB[b]) mem[w_idx_q][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/axi4_burst_mem_slave.md
# axi4_burst_mem_slave

Parametrised AXI4 full-protocol memory slave: the next generation of our AXI full slave IP, exercised by the master BFM in the block-design bench. It generalises data width and memory depth, and supports FIXED, INCR and WRAP bursts of up to 256 beats with byte strobes. It adds SLVERR signalling for illegal bursts. Write and read channels run as independent state machines over a shared register array, one outstanding transaction per direction.

## Interface
- C_S_AXI_ID_WIDTH, 4, AWID/BID/ARID/RID width
- C_S_AXI_DATA_WIDTH, 32, data width; legal values 32, 64, 128
- C_S_AXI_ADDR_WIDTH, 10, byte address width; memory is 2^C_S_AXI_ADDR_WIDTH bytes
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]  in  write address; AWVALID in 1, AWREADY out 1
- WDATA  in  DATA_WIDTH; WSTRB in DATA_WIDTH/8; WLAST in 1; WVALID in 1; WREADY out 1
- BID  out  ID_WIDTH; BRESP out 2; BVALID out 1; BREADY in 1
- ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]  in  read address; ARVALID in 1, ARREADY out 1
- RID  out  ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1
- Cache, prot, QoS, region, lock and user signals are not ported; they are tied off in the wrapper.

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, address, length, burst and size. Compute the error flag and move to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes selected by WSTRB at the current word, unless the error flag is set. The address then advances. After beat AWLEN+1, go to W_RESP.
  - WLAST asserted on any beat other than the last, or absent on the last, sets the error flag; the beat count still governs termination.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 if the error flag is set, else 2'b00. Leave on BVALID&&BREADY.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. The AR handshake latches the burst.
  - R_DATA: RVALID=1. RDATA is the word at the current address, or 0 on error. RRESP is per beat. RLAST=1 on beat ARLEN+1. Each R handshake advances the address; the handshake with RLAST returns to R_IDLE.
- Address arithmetic operates on the word index (addr >> log2(DATA_WIDTH/8)), bytes per beat = DATA_WIDTH/8.
  - FIXED: no change.
  - INCR: +1, truncated to the index width, so the address wraps at the top of memory.
  - WRAP: mask = LEN; next = (idx & ~mask) | ((idx+1) & mask).
  - The low address bits of an unaligned start are ignored.
- Error conditions (SLVERR, no memory write, read data 0, full beat count still transferred):
  - AxSIZE != log2(DATA_WIDTH/8)
  - AxBURST == 2'b11
  - WRAP with LEN not in {1,3,7,15}
- A simultaneous write and read to the same word in one cycle returns the old data.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0. Memory is not reset.
- AWREADY and ARREADY rise on the first ACLK edge after ARESET deasserts.
- Write: WREADY asserts the cycle after the AW handshake. BVALID asserts the cycle after the last W handshake. AWREADY reasserts the cycle after the B handshake.
- Throughput is 1 beat per cycle on W and R.
- Read: first RVALID is the cycle after the AR handshake.
- RDATA, RRESP, RLAST and RID are held stable while RVALID && !RREADY.
- ARESET mid-burst: both FSMs go idle immediately and in-flight beats are dropped. Words already written are retained.
- The two channels never stall each other.

## Configuration
- AXI4_BURST_MEM_WRAP_EN defined: WRAP bursts are supported as above.
- AXI4_BURST_MEM_WRAP_EN undefined: the wrap logic is compiled out. AxBURST == 2'b10 is treated as an error burst (SLVERR, writes discarded, read data 0, LEN+1 beats).

## Test plan
- INCR write at 0x000, LEN=15, data 0xFFFFFFFF..0x00abcdef, then INCR read of the same burst -> identical 16 words, BRESP=0 and all RRESP=0, RLAST only on beat 16.
- Preload words 0..3 = 0xA0..0xA3; WRAP read at 0x008, LEN=3 (WRAP_EN defined) -> RDATA order 0xA2, 0xA3, 0xA0, 0xA1.
- FIXED write at 0x010, LEN=3, data 1,2,3,4, with WSTRB=4'b0011 on the last beat -> word 4 reads 0x00000004 when a prior value of 0 is present.
- ARSIZE=3'b001 read, LEN=1 -> 2 beats, RDATA=0, RRESP=2'b10 each beat; AWBURST=2'b11 write -> memory unchanged, BRESP=2'b10.
- INCR read LEN=7 with RREADY toggling 1,0,0,1… -> no beat lost or duplicated, RDATA held stable during stalls; a concurrent write completes in parallel.
- ARESET pulsed after beat 3 of a LEN=7 write -> all ready/valid outputs 0 during reset, AWREADY=1 one edge after release, words 0–2 retained.
